// File: rtl/imem_prefetch_buf_pkg.sv
// rtl/imem_prefetch_buf_pkg.sv - shared types for the instruction prefetch buffer
package pkg_fetch;

    localparam int unsigned PcWidth = 32;

    // One buffered fetch: the word returned by imem and the PC it was fetched from.
    typedef struct packed {
        logic [PcWidth-1:0] pc;
        logic [PcWidth-1:0] inst;
    } fetch_entry_t;

    // IDLE: nothing outstanding. REQ: outstanding, response will be buffered.
    // DROP: outstanding, response belongs to a flushed stream and is thrown away.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } pf_state_e;

    // Instruction fetches are always word aligned; low two address bits are forced to zero.
    function automatic logic [PcWidth-1:0] align_word(input logic [PcWidth-1:0] addr);
        return {addr[PcWidth-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/imem_prefetch_buf_fifo.sv
// rtl/imem_prefetch_buf_fifo.sv - small registered FIFO of fetch entries with flush
module fetch_fifo
    import pkg_fetch::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  fetch_entry_t             entry_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AW = $clog2(Depth);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    fetch_entry_t mem_q [Depth];
    fetch_entry_t mem_d [Depth];

    // Next-state for storage and pointers; flush wins over push and pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q[AW-1:0]] = entry_i;
                wr_ptr_d                = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage and pointer registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/imem_prefetch_buf.sv
// rtl/imem_prefetch_buf.sv - sequential instruction prefetcher with redirect flush
module imem_prefetch_buf
    import pkg_fetch::*;
#(
    parameter int unsigned      DWidth  = 32,
    parameter int unsigned      Depth   = 4,
    parameter logic [DWidth-1:0] ResetPc = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              redirect_i,
    input  logic [DWidth-1:0] redirect_pc_i,
    output logic              inst_valid_o,
    output logic [DWidth-1:0] inst_o,
    output logic [DWidth-1:0] inst_pc_o,
    input  logic              inst_ready_i,
    output logic              imem_req_o,
    output logic [DWidth-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic [DWidth-1:0] imem_rdata_i
);

    localparam int unsigned CW = $clog2(Depth) + 1;

    pf_state_e         state_q, state_d;
    logic              req_q, req_d;
    logic [DWidth-1:0] addr_q, addr_d;
    logic [DWidth-1:0] fetch_pc_q, fetch_pc_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     count_after;
    logic              slot_left;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic [DWidth-1:0] redirect_pc;
    logic [DWidth-1:0] pc_next;

    assign redirect_pc = align_word(redirect_pc_i);
    assign pc_next     = fetch_pc_q + DWidth'(4);

    // A redirect cancels any pop or push at its edge; only REQ responses are ever buffered.
    assign fifo_pop  = inst_valid_o && inst_ready_i && !redirect_i;
    assign fifo_push = (state_q == REQ) && imem_ready_i && !redirect_i;

    assign push_entry.pc   = fetch_pc_q;
    assign push_entry.inst = imem_rdata_i;

    // Occupancy after this edge decides whether the next request may be issued back-to-back.
    assign count_after = fifo_count + {{(CW-1){1'b0}}, fifo_push} - {{(CW-1){1'b0}}, fifo_pop};
    assign slot_left   = (count_after < CW'(Depth));

    fetch_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .entry_i (push_entry),
        .pop_i   (fifo_pop),
        .flush_i (redirect_i),
        .head_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Fetch FSM next-state: request issue, completion, and redirect handling.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                end else if (!fifo_full) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                    if (imem_ready_i) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ready_i) begin
                    fetch_pc_d = pc_next;
                    if (slot_left) begin
                        addr_d = pc_next;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            DROP: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                end
                if (imem_ready_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Fetch FSM registers; request and address outputs come straight from flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= ResetPc;
            fetch_pc_q <= ResetPc;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign inst_valid_o = !fifo_empty;
    assign inst_o       = head_entry.inst;
    assign inst_pc_o    = head_entry.pc;

endmodule
